// File: rtl/mem_issue_queue.sv
// In-order load/store issue queue between EXE and MEM. Stores wait for a ROB commit credit.
// Optional feature macro MEMQ_EMPTY_BYPASS_EN: a load meeting an empty queue goes straight to the output registers.
module mem_issue_queue #(
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3,
    parameter int CRED_W = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [31:0]       enq_instr,
    input  logic [31:0]       enq_pc,
    input  logic [31:0]       enq_alu_result,
    input  logic [31:0]       enq_mem_wdata,
    input  logic [5:0]        enq_alu_control,
    input  logic [4:0]        enq_wreg,
    input  logic              enq_regwrite,
    input  logic              enq_memread,
    input  logic              enq_memwrite,
    input  logic [5:0]        enq_map,
    input  logic              store_commit,
    input  logic              flush,
    output logic [31:0]       Instr1_OUT,
    output logic [31:0]       Instr1_PC_OUT,
    output logic [31:0]       ALU_result1_OUT,
    output logic [31:0]       MemWriteData1_OUT,
    output logic [5:0]        ALU_Control1_OUT,
    output logic [4:0]        WriteRegister1_OUT,
    output logic              RegWrite1_OUT,
    output logic              MemRead1_OUT,
    output logic              MemWrite1_OUT,
    output logic [5:0]        RegWr_map_OUT,
    output logic [PTR_W:0]    count,
    output logic [CRED_W-1:0] credits
);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] alu_result;
        logic [31:0] wdata;
        logic [5:0]  alu_control;
        logic [4:0]  wreg;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic [5:0]  map;
    } mem_op_t;

    mem_op_t            queue_mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    mem_op_t            out_q;
    mem_op_t            out_next;
    mem_op_t            enq_op;
    mem_op_t            head_op;
    logic               head_eligible;
    logic               store_issue;
    logic               bypass_take;
    logic               enq_write;
    logic [PTR_W:0]     count_next;
    logic [CRED_W-1:0]  credits_next;

    assign enq_op = {enq_instr, enq_pc, enq_alu_result, enq_mem_wdata, enq_alu_control,
                     enq_wreg, enq_regwrite, enq_memread, enq_memwrite, enq_map};
    assign head_op   = queue_mem[head];
    assign enq_ready = (count != (PTR_W+1)'(DEPTH));

    // A blocked store at the head stalls everything behind it; there is no bypass around it.
    assign head_eligible = (count != '0) && (!head_op.memwrite || (credits != '0));
    assign store_issue   = head_eligible && head_op.memwrite;

`ifdef MEMQ_EMPTY_BYPASS_EN
    assign bypass_take = (count == '0) && enq_valid && !enq_memwrite;
`else
    assign bypass_take = 1'b0;
`endif

    assign enq_write = enq_valid && enq_ready && !bypass_take;

    // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        out_next     = '0;
        count_next   = count;
        credits_next = credits;

        if (head_eligible)
            out_next = head_op;
        else if (bypass_take)
            out_next = enq_op;

        case ({enq_write, head_eligible})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase

        if (store_commit && !store_issue) begin
            if (credits != '1)
                credits_next = credits + 1'b1;
        end else if (!store_commit && store_issue) begin
            credits_next = credits - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET || flush) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            credits <= '0;
            out_q   <= '0;
        end else begin
            if (head_eligible)
                head <= head + 1'b1;
            if (enq_write)
                tail <= tail + 1'b1;
            count   <= count_next;
            credits <= credits_next;
            out_q   <= out_next;
        end
    end

    // NOTE: queue storage has no reset; entries are only read once count says they were written.
    always_ff @(posedge CLK) begin
        if (enq_write)
            queue_mem[tail] <= enq_op;
    end

    assign Instr1_OUT         = out_q.instr;
    assign Instr1_PC_OUT      = out_q.pc;
    assign ALU_result1_OUT    = out_q.alu_result;
    assign MemWriteData1_OUT  = out_q.wdata;
    assign ALU_Control1_OUT   = out_q.alu_control;
    assign WriteRegister1_OUT = out_q.wreg;
    assign RegWrite1_OUT      = out_q.regwrite;
    assign MemRead1_OUT       = out_q.memread;
    assign MemWrite1_OUT      = out_q.memwrite;
    assign RegWr_map_OUT      = out_q.map;

endmodule
